// File: rtl/rv_decode.sv
// RV32I decode stage: captures fetched instructions, decodes fields and
// immediates, buffers one extra entry in a skid register, and steers fetch redirects.
module rv_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] Inst,
    input  logic        isInstValid,
    output logic        FetchStall,
    output logic        FetchJump,
    output logic [31:0] TargetPC,
    input  logic        ExRedirect,
    input  logic [31:0] ExTargetPC,
    output logic        DecValid,
    input  logic        ExReady,
    output logic [31:0] DecPC,
    output logic [31:0] DecInst,
    output logic [4:0]  DecRd,
    output logic [4:0]  DecRs1,
    output logic [4:0]  DecRs2,
    output logic [31:0] DecImm,
    output logic        DecIllegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    dec_t        out_q, out_d, sk_q, sk_d, new_dec;
    logic        out_v_q, out_v_d, sk_v_q, sk_v_d;
    logic        parked_q, parked_d;
    logic        jal_pend_q, jal_pend_d, rd_pend_q, rd_pend_d;
    logic [31:0] jal_tgt_q, jal_tgt_d, rd_tgt_q, rd_tgt_d;
    logic [31:0] imm;
    logic        ill, is_jal, full, capture, jal_fire;

    // Immediate extraction and legality check from the incoming opcode
    always_comb begin
        imm    = '0;
        ill    = 1'b0;
        is_jal = 1'b0;
        unique case (Inst[6:0])
            7'b0110111, 7'b0010111:
                imm = {Inst[31:12], 12'b0};
            7'b1101111: begin
                imm = {{12{Inst[31]}}, Inst[19:12], Inst[20],
                       Inst[30:21], 1'b0};
                is_jal = 1'b1;
            end
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:
                imm = {{20{Inst[31]}}, Inst[31:20]};
            7'b1100011:
                imm = {{20{Inst[31]}}, Inst[7], Inst[30:25],
                       Inst[11:8], 1'b0};
            7'b0100011:
                imm = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
            7'b0110011:
                imm = '0;
            default:
                ill = 1'b1;
        endcase
    end

    assign new_dec = '{pc: PC, inst: Inst, rd: Inst[11:7],
                       rs1: Inst[19:15], rs2: Inst[24:20],
                       imm: imm, ill: ill};

    assign full       = sk_v_q | (out_v_q & ~ExReady);
    assign FetchStall = full;
    assign capture    = isInstValid & ~ExRedirect & ~rd_pend_q;

    // Fetch redirect selection: execute redirect, held redirect, local JAL
    always_comb begin
        FetchJump = 1'b0;
        TargetPC  = '0;
        jal_fire  = 1'b0;
        if (ExRedirect) begin
            if (isInstValid | parked_q) begin
                FetchJump = 1'b1;
                TargetPC  = ExTargetPC;
            end
        end else if (rd_pend_q) begin
            FetchJump = 1'b1;
            TargetPC  = rd_tgt_q;
        end else if (capture & is_jal & ~full) begin
            FetchJump = 1'b1;
            TargetPC  = PC + imm;
        end else if (parked_q & ~full & jal_pend_q) begin
            FetchJump = 1'b1;
            TargetPC  = jal_tgt_q;
            jal_fire  = 1'b1;
        end
    end

    // Buffer, parked-tracking and pending-redirect next state
    always_comb begin
        out_d      = out_q;
        out_v_d    = out_v_q;
        sk_d       = sk_q;
        sk_v_d     = sk_v_q;
        parked_d   = parked_q;
        jal_pend_d = jal_pend_q;
        jal_tgt_d  = jal_tgt_q;
        rd_pend_d  = rd_pend_q;
        rd_tgt_d   = rd_tgt_q;

        if (isInstValid & full & ~FetchJump)
            parked_d = 1'b1;
        else if (parked_q & (~full | FetchJump))
            parked_d = 1'b0;

        if (ExRedirect) begin
            out_v_d    = 1'b0;
            sk_v_d     = 1'b0;
            jal_pend_d = 1'b0;
            rd_pend_d  = ~(isInstValid | parked_q);
            rd_tgt_d   = ExTargetPC;
        end else begin
            if (rd_pend_q & (isInstValid | parked_q))
                rd_pend_d = 1'b0;
            if (jal_fire)
                jal_pend_d = 1'b0;
            if (out_v_q & ExReady) begin
                if (sk_v_q) begin
                    out_d  = sk_q;
                    sk_v_d = 1'b0;
                end else begin
                    out_v_d = 1'b0;
                end
            end
            if (capture) begin
                if (~sk_v_q & (~out_v_q | ExReady)) begin
                    out_d   = new_dec;
                    out_v_d = 1'b1;
                end else begin
                    sk_d   = new_dec;
                    sk_v_d = 1'b1;
                end
                if (is_jal & full) begin
                    jal_pend_d = 1'b1;
                    jal_tgt_d  = PC + imm;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            out_v_q    <= 1'b0;
            sk_q       <= '0;
            sk_v_q     <= 1'b0;
            parked_q   <= 1'b0;
            jal_pend_q <= 1'b0;
            jal_tgt_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_tgt_q   <= '0;
        end else begin
            out_q      <= out_d;
            out_v_q    <= out_v_d;
            sk_q       <= sk_d;
            sk_v_q     <= sk_v_d;
            parked_q   <= parked_d;
            jal_pend_q <= jal_pend_d;
            jal_tgt_q  <= jal_tgt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tgt_q   <= rd_tgt_d;
        end
    end

    assign DecValid   = out_v_q;
    assign DecPC      = out_q.pc;
    assign DecInst    = out_q.inst;
    assign DecRd      = out_q.rd;
    assign DecRs1     = out_q.rs1;
    assign DecRs2     = out_q.rs2;
    assign DecImm     = out_q.imm;
    assign DecIllegal = out_q.ill;

endmodule

// File: tb/tb_rv_decode.sv
// Directed bench for rv_decode: vector table for streaming, back-pressure
// and JAL handling, plus hand sequences for redirects and reset.
module tb_rv_decode;

    logic        clk, rst;
    logic [31:0] PC, Inst, TargetPC, ExTargetPC;
    logic        isInstValid, FetchStall, FetchJump, ExRedirect;
    logic        DecValid, ExReady, DecIllegal;
    logic [31:0] DecPC, DecInst, DecImm;
    logic [4:0]  DecRd, DecRs1, DecRs2;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] ADDI5  = 32'h0050_0093;
    localparam logic [31:0] ADDIM1 = 32'hFFF0_0113;
    localparam logic [31:0] LUI    = 32'h1234_52B7;
    localparam logic [31:0] SW     = 32'h0020_A423;
    localparam logic [31:0] BEQM4  = 32'hFE00_0EE3;
    localparam logic [31:0] ADD    = 32'h0020_81B3;
    localparam logic [31:0] BAD    = 32'h0000_007F;
    localparam logic [31:0] JAL16  = 32'h0100_00EF;
    localparam logic [31:0] JALM8  = 32'hFF9F_F06F;

    rv_decode dut (
        .clk(clk), .rst(rst), .PC(PC), .Inst(Inst),
        .isInstValid(isInstValid), .FetchStall(FetchStall),
        .FetchJump(FetchJump), .TargetPC(TargetPC),
        .ExRedirect(ExRedirect), .ExTargetPC(ExTargetPC),
        .DecValid(DecValid), .ExReady(ExReady),
        .DecPC(DecPC), .DecInst(DecInst), .DecRd(DecRd),
        .DecRs1(DecRs1), .DecRs2(DecRs2), .DecImm(DecImm),
        .DecIllegal(DecIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && isInstValid && !ExRedirect)
            assert (!dut.sk_v_q)
            else begin
                fails++;
                $display("FAIL protocol: isInstValid while skid full");
            end

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        xj;
        logic [31:0] xt;
        logic        xs;
        logic        xdv;
        logic [31:0] xpc;
        logic [31:0] ximm;
        logic [4:0]  xrd;
        logic        xill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] inst,
                                logic rdy, logic xj, logic [31:0] xt,
                                logic xs, logic xdv, logic [31:0] xpc,
                                logic [31:0] ximm, logic [4:0] xrd,
                                logic xill);
        vec_t r;
        r = '{v, pc, inst, rdy, xj, xt, xs, xdv, xpc, ximm, xrd, xill};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy,
                         input logic red, input logic [31:0] rtgt);
        @(negedge clk);
        isInstValid = v;
        PC          = pc;
        Inst        = inst;
        ExReady     = rdy;
        ExRedirect  = red;
        ExTargetPC  = rtgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        isInstValid = 1'b0; PC = '0; Inst = '0;
        ExReady = 1'b0; ExRedirect = 1'b0; ExTargetPC = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset DecValid", {31'b0, DecValid}, 0);
        chk("reset FetchStall", {31'b0, FetchStall}, 0);
        chk("reset FetchJump", {31'b0, FetchJump}, 0);
        chk("reset TargetPC", TargetPC, 0);
        chk("reset DecPC", DecPC, 0);
        chk("reset DecInst", DecInst, 0);
        chk("reset DecImm", DecImm, 0);

        // v pc inst rdy | jump tgt stall | dv pc imm rd ill
        vecs.push_back(mk(1, 32'h00, ADDI5,  1, 0, 0, 0, 1, 32'h00, 5, 1, 0));
        vecs.push_back(mk(1, 32'h04, ADDIM1, 1, 0, 0, 0, 1, 32'h04, 32'hFFFFFFFF, 2, 0));
        vecs.push_back(mk(1, 32'h08, LUI,    1, 0, 0, 0, 1, 32'h08, 32'h12345000, 5, 0));
        vecs.push_back(mk(1, 32'h0C, SW,     1, 0, 0, 0, 1, 32'h0C, 8, 8, 0));
        vecs.push_back(mk(1, 32'h10, BEQM4,  1, 0, 0, 0, 1, 32'h10, 32'hFFFFFFFC, 29, 0));
        vecs.push_back(mk(1, 32'h14, ADD,    1, 0, 0, 0, 1, 32'h14, 0, 3, 0));
        vecs.push_back(mk(1, 32'h18, BAD,    1, 0, 0, 0, 1, 32'h18, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00, ADDI5,  0, 0, 0, 0, 1, 32'h00, 5, 1, 0));
        vecs.push_back(mk(1, 32'h04, ADDIM1, 0, 0, 0, 1, 1, 32'h00, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0,           0, 0, 0, 1, 1, 32'h00, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 1, 1, 32'h04, 32'hFFFFFFFF, 2, 0));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h100, JAL16, 1, 1, 32'h110, 0, 1, 32'h100, 16, 1, 0));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1F0, ADDI5, 0, 0, 0, 0, 1, 32'h1F0, 5, 1, 0));
        vecs.push_back(mk(1, 32'h200, JALM8, 0, 0, 0, 1, 1, 32'h1F0, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 1, 1, 32'h200, 32'hFFFFFFF8, 0, 0));
        vecs.push_back(mk(0, 0, 0,           1, 1, 32'h1F8, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].rdy, 0, 0);
            chk($sformatf("r%0d FetchJump", i), {31'b0, FetchJump}, {31'b0, vecs[i].xj});
            chk($sformatf("r%0d TargetPC", i), TargetPC, vecs[i].xt);
            chk($sformatf("r%0d FetchStall", i), {31'b0, FetchStall}, {31'b0, vecs[i].xs});
            tick();
            chk($sformatf("r%0d DecValid", i), {31'b0, DecValid}, {31'b0, vecs[i].xdv});
            if (vecs[i].xdv) begin
                chk($sformatf("r%0d DecPC", i), DecPC, vecs[i].xpc);
                chk($sformatf("r%0d DecImm", i), DecImm, vecs[i].ximm);
                chk($sformatf("r%0d DecRd", i), {27'b0, DecRd}, {27'b0, vecs[i].xrd});
                chk($sformatf("r%0d DecIllegal", i), {31'b0, DecIllegal}, {31'b0, vecs[i].xill});
            end
        end

        // Redirect with nothing in flight: held until next delivery
        drive(1, 32'h300, ADDI5, 0, 0, 0);
        tick();
        chk("redir preload DecValid", {31'b0, DecValid}, 1);
        drive(0, 0, 0, 0, 1, 32'h400);
        chk("redir cyc0 FetchJump", {31'b0, FetchJump}, 0);
        tick();
        chk("redir flush DecValid", {31'b0, DecValid}, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("redir hold1 FetchJump", {31'b0, FetchJump}, 1);
        chk("redir hold1 TargetPC", TargetPC, 32'h400);
        chk("redir hold1 FetchStall", {31'b0, FetchStall}, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk("redir hold2 TargetPC", TargetPC, 32'h400);
        tick();
        drive(1, 32'h400, ADDI5, 1, 0, 0);
        chk("redir consume FetchJump", {31'b0, FetchJump}, 1);
        chk("redir consume TargetPC", TargetPC, 32'h400);
        tick();
        chk("redir discard DecValid", {31'b0, DecValid}, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("redir done FetchJump", {31'b0, FetchJump}, 0);
        tick();
        chk("redir done DecValid", {31'b0, DecValid}, 0);

        // Redirect coincident with a JAL delivery
        drive(1, 32'h100, JAL16, 1, 1, 32'h600);
        chk("coinc FetchJump", {31'b0, FetchJump}, 1);
        chk("coinc TargetPC", TargetPC, 32'h600);
        tick();
        chk("coinc DecValid", {31'b0, DecValid}, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("coinc after FetchJump", {31'b0, FetchJump}, 0);
        tick();

        // Reset while stalled with a pending JAL
        drive(1, 32'h0, ADDI5, 0, 0, 0);
        tick();
        drive(1, 32'h200, JALM8, 0, 0, 0);
        chk("prerst FetchStall", {31'b0, FetchStall}, 1);
        chk("prerst FetchJump", {31'b0, FetchJump}, 0);
        tick();
        chk("prerst DecValid", {31'b0, DecValid}, 1);
        @(negedge clk);
        isInstValid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst FetchStall", {31'b0, FetchStall}, 0);
        chk("rst DecValid", {31'b0, DecValid}, 0);
        chk("rst FetchJump", {31'b0, FetchJump}, 0);
        chk("rst TargetPC", TargetPC, 0);
        chk("rst DecPC", DecPC, 0);
        chk("rst DecImm", DecImm, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 0);
        chk("postrst FetchJump", {31'b0, FetchJump}, 0);
        chk("postrst FetchStall", {31'b0, FetchStall}, 0);
        tick();
        chk("postrst DecValid", {31'b0, DecValid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_decode.md
# rv_decode

Decode stage directly downstream of the instruction fetch stage. It captures each fetched instruction, extracts the RV32I register fields and immediate, and presents them to execute through a valid/ready handshake. It drives the fetch stage's stall/jump/target inputs: JAL is resolved locally, and branch/JALR redirects from execute are forwarded. A one-entry skid buffer is required because fetch does not re-present an instruction that was delivered while stalled.

## Interface
- No parameters.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- PC  in  32  fetch PC of Inst
- Inst  in  32  fetched instruction word
- isInstValid  in  1  Inst/PC valid this cycle (single-cycle pulse per instruction)
- FetchStall  out  1  hold fetch after the current delivery
- FetchJump  out  1  redirect fetch to TargetPC
- TargetPC  out  32  redirect target
- ExRedirect  in  1  branch/JALR redirect from execute (1-cycle pulse)
- ExTargetPC  in  32  redirect target from execute
- DecValid  out  1  decoded instruction valid
- ExReady  in  1  execute accepts this cycle
- DecPC, DecInst  out  32 each  PC and raw word
- DecRd, DecRs1, DecRs2  out  5 each  Inst[11:7], [19:15], [24:20]
- DecImm  out  32  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type)
- DecIllegal  out  1  opcode[6:0] not in the RV32I base set or [1:0] != 2'b11

## Operation
- Storage: out register (out_v plus fields) and skid register (sk_v plus fields). Decoded fields are computed at capture and stored.
- full = sk_v | (out_v & !ExReady). FetchStall = full (combinational).
- Capture on isInstValid when no flush is active:
  - if out_v is 0 or ExReady is 1, and sk_v is 0: load into out;
  - otherwise load into skid.
  - isInstValid with sk_v=1 is a protocol violation; the bench asserts it never happens.
- Drain: on ExReady & out_v, the skid moves to out if sk_v, else out_v clears.
- parked flag mirrors fetch's stall-hold state:
  - set on isInstValid & FetchStall & !FetchJump;
  - cleared on parked & (!FetchStall | FetchJump).
- JAL (opcode 1101111), target = PC + J-imm:
  - captured with full=0: FetchJump=1 in the same cycle, TargetPC=PC+J-imm.
  - captured with full=1: FetchJump=0, and jal_pend/jal_tgt are set. Later, while parked & !full & jal_pend, FetchJump=1 with TargetPC=jal_tgt, and jal_pend clears.
  - The JAL itself always proceeds to execute (for the rd write).
- ExRedirect has priority over everything:
  - out_v, sk_v and jal_pend clear next cycle;
  - any isInstValid in the same cycle is discarded.
  - If isInstValid | parked in that cycle, FetchJump=1 with TargetPC=ExTargetPC immediately.
  - Otherwise set rd_pend/rd_tgt.
- While rd_pend: FetchJump=1, TargetPC=rd_tgt, and every isInstValid is discarded. rd_pend clears on the cycle isInstValid | parked (fetch consumes the jump). A new ExRedirect overwrites rd_tgt.
- Address arithmetic is mod 2^32 and wraps silently.

## Timing
- Reset: all valids/pends/parked = 0. FetchJump=0, FetchStall=0, TargetPC=0, DecValid=0, and all Dec* fields = 0.
- Capture to DecValid latency: 1 cycle.
- Execute handshake: transfer when DecValid & ExReady. Dec* are stable while DecValid & !ExReady.
- FetchJump/TargetPC are combinational from isInstValid, PC, Inst, ExRedirect and state, and valid in the same cycle as isInstValid.
- Reset asserted mid-operation clears all state asynchronously; pending redirects are lost.

## Test plan
- Stream: ADDI x1,x0,5 at PC 0, then PC 4, with ExReady=1 -> DecValid one cycle after each capture; DecImm=5, DecRd=1; FetchStall never 1.
- Back-pressure: ExReady=0, two instructions at PC 0 and PC 4 -> second lands in skid, FetchStall=1, fetch parks. Raise ExReady -> PC 0 then PC 4 issue on consecutive cycles; FetchStall drops once the skid is empty.
- JAL x1,+16 at PC 0x100 with no stall -> same cycle FetchJump=1, TargetPC=0x110; DecImm=16 next cycle.
- JAL at PC 0x200, offset -8, arriving while full -> FetchJump=0, FetchStall=1. After drain and parked: FetchJump=1, TargetPC=0x1F8, exactly one pulse.
- ExRedirect to 0x400 with no delivery in flight -> FetchJump held to 0x400 until next isInstValid; that instruction is discarded and DecValid stays 0. Buffers flushed the cycle after ExRedirect.
- ExRedirect coincident with isInstValid and a JAL -> TargetPC=ExTargetPC, JAL discarded; rst pulse mid-stall -> all outputs 0 immediately.
